// File: rtl/fm_bram_dp.sv
`default_nettype none
// ============================================================================
// Module   : fm_bram_dp
// Purpose  : True dual-port, byte-writable feature-map block RAM with a
//            reset-triggered clear sequencer, selectable same-port
//            read-during-write mode and an optional output register stage.
// Ports    : clk, rst        - single clock, synchronous active-high reset
//            init_busy       - high while the array is being zeroed
//            a_* / b_*       - en, we (byte lanes), addr, din, dout, vld
//                              port A: DDR streaming engine
//                              port B: compute datapath
// Revision : 1.0 - initial dual-port release
// ============================================================================
module fm_bram_dp #(
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int BRAM_DATA_WIDTH = 64,
  parameter int BRAM_DEPTH      = 64,
  parameter int BYTE_WIDTH      = 8,
  parameter int READ_MODE       = 0,  // 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
  parameter int OUT_REG         = 0,
  parameter int CLEAR_ON_RESET  = 1,
  localparam int NB = BRAM_DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       init_busy,
  input  logic                       a_en,
  input  logic [NB-1:0]              a_we,
  input  logic [BRAM_ADDR_WIDTH-1:0] a_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] a_din,
  output logic [BRAM_DATA_WIDTH-1:0] a_dout,
  output logic                       a_vld,
  input  logic                       b_en,
  input  logic [NB-1:0]              b_we,
  input  logic [BRAM_ADDR_WIDTH-1:0] b_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] b_din,
  output logic [BRAM_DATA_WIDTH-1:0] b_dout,
  output logic                       b_vld
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Array index width, independent of the (possibly wider) address width.
  localparam int IW = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1;
  localparam logic [IW-1:0]            LAST_IDX  = IW'(BRAM_DEPTH - 1);
  localparam logic [BRAM_ADDR_WIDTH:0] DEPTH_EXT = (BRAM_ADDR_WIDTH + 1)'(BRAM_DEPTH);

  logic [BRAM_DATA_WIDTH-1:0] mem [BRAM_DEPTH];

  logic [0:0]    state;
  logic [IW-1:0] clr_cnt;
  logic          ready;

  // Both ports folded into two-entry arrays so one generate body serves both.
  logic [1:0]                 en;
  logic [NB-1:0]              we     [2];
  logic [BRAM_ADDR_WIDTH-1:0] addr   [2];
  logic [BRAM_DATA_WIDTH-1:0] din    [2];
  logic [IW-1:0]              idx    [2];
  logic [BRAM_DATA_WIDTH-1:0] old_w  [2];
  logic [BRAM_DATA_WIDTH-1:0] rd_w   [2];
  logic [BRAM_DATA_WIDTH-1:0] q_out  [2];
  logic [1:0]                 acc;
  logic [1:0]                 wr;
  logic [1:0]                 inr;
  logic [1:0]                 upd;
  logic [1:0]                 v_out;

  assign en      = {b_en, a_en};
  assign we[0]   = a_we;
  assign we[1]   = b_we;
  assign addr[0] = a_addr;
  assign addr[1] = b_addr;
  assign din[0]  = a_din;
  assign din[1]  = b_din;

  assign ready     = (state == ST_READY) && !rst;
  assign init_busy = (state == ST_CLEAR);

  // --------------------------------------------------------------------------
  // Control FSM and clear counter. A reset anywhere restarts the clear from
  // word 0; the array is only touched on cycles with rst low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == LAST_IDX) begin
        state <= ST_READY;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Array writes. Port B is applied first and port A last so that A wins on
  // byte lanes both ports enable; lanes enabled by one port only keep that
  // port's data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else begin
        for (int p = 1; p >= 0; p--) begin
          for (int i = 0; i < NB; i++) begin
            if (acc[p] && inr[p] && we[p][i]) begin
              mem[idx[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-port read path. The read samples the array before this edge's writes,
  // so a cross-port read of a word being written returns the old word.
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [BRAM_DATA_WIDTH-1:0] merged;
    logic [BRAM_DATA_WIDTH-1:0] q1;
    logic                       v1;
    logic                       nc_wr;

    assign inr[p]   = ({1'b0, addr[p]} < DEPTH_EXT);
    assign idx[p]   = addr[p][IW-1:0];
    assign acc[p]   = en[p] & ready;
    assign wr[p]    = |we[p];
    assign old_w[p] = inr[p] ? mem[idx[p]] : '0;

    for (genvar i = 0; i < NB; i++) begin : g_lane
      assign merged[i*BYTE_WIDTH +: BYTE_WIDTH] = we[p][i] ? din[p][i*BYTE_WIDTH +: BYTE_WIDTH]
                                                           : old_w[p][i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    // Out-of-range accesses always return zero, including WRITE_FIRST writes.
    assign rd_w[p] = ((READ_MODE == 1) && wr[p]) ? (inr[p] ? merged : '0) : old_w[p];

    // NO_CHANGE writes neither update dout nor raise vld.
    assign nc_wr  = wr[p] & (READ_MODE == 2);
    assign upd[p] = acc[p] & ~nc_wr;

    always_ff @(posedge clk) begin
      if (rst) begin
        q1 <= '0;
        v1 <= 1'b0;
      end else begin
        v1 <= upd[p];
        if (upd[p]) begin
          q1 <= rd_w[p];
        end
      end
    end

    if (OUT_REG != 0) begin : g_out_reg
      logic [BRAM_DATA_WIDTH-1:0] q2;
      logic                       v2;
      always_ff @(posedge clk) begin
        if (rst) begin
          q2 <= '0;
          v2 <= 1'b0;
        end else begin
          q2 <= q1;
          v2 <= v1;
        end
      end
      assign q_out[p] = q2;
      assign v_out[p] = v2;
    end else begin : g_no_out_reg
      assign q_out[p] = q1;
      assign v_out[p] = v1;
    end
  end

  assign a_dout = q_out[0];
  assign a_vld  = v_out[0];
  assign b_dout = q_out[1];
  assign b_vld  = v_out[1];

endmodule
`default_nettype wire

// File: tb/tb_fm_bram_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_fm_bram_dp
// Purpose  : Self-checking bench for fm_bram_dp. Three instances share one
//            stimulus: READ_FIRST/no out reg (rf), WRITE_FIRST/out reg (wf)
//            and NO_CHANGE/no out reg (nc), all 64 words with a 7-bit address
//            so out-of-range addresses can be exercised.
// Revision : 1.0 - initial bench
// ============================================================================
module tb_fm_bram_dp;
  localparam int AW = 7;
  localparam int DW = 64;
  localparam int NB = 8;

  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] M3 = 64'h1111_2222_CCCC_DDDD;
  localparam logic [63:0] A8 = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] B8 = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] O1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] T2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] C9 = 64'hAAAA_2222_1111_1111;
  localparam logic [63:0] W9 = 64'hAAAA_AAAA_1111_1111;
  localparam logic [63:0] F5 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_en, b_en;
  logic [NB-1:0] a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;

  logic [DW-1:0] rf_a_dout, rf_b_dout, wf_a_dout, wf_b_dout, nc_a_dout, nc_b_dout;
  logic          rf_a_vld, rf_b_vld, wf_a_vld, wf_b_vld, nc_a_vld, nc_b_vld;
  logic          rf_busy, wf_busy, nc_busy;

  fm_bram_dp #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .BRAM_DEPTH(64), .BYTE_WIDTH(8),
               .READ_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_rf (
    .clk(clk), .rst(rst), .init_busy(rf_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(rf_a_dout), .a_vld(rf_a_vld),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(rf_b_dout), .b_vld(rf_b_vld));

  fm_bram_dp #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .BRAM_DEPTH(64), .BYTE_WIDTH(8),
               .READ_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_wf (
    .clk(clk), .rst(rst), .init_busy(wf_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(wf_a_dout), .a_vld(wf_a_vld),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(wf_b_dout), .b_vld(wf_b_vld));

  fm_bram_dp #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .BRAM_DEPTH(64), .BYTE_WIDTH(8),
               .READ_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_nc (
    .clk(clk), .rst(rst), .init_busy(nc_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(nc_a_dout), .a_vld(nc_a_vld),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(nc_b_dout), .b_vld(nc_b_vld));

  typedef struct {
    logic          a_en;
    logic [NB-1:0] a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic          b_en;
    logic [NB-1:0] b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din;
    logic [DW-1:0] rf_a;
    logic          rf_av;
    logic [DW-1:0] rf_b;
    logic          rf_bv;
    logic [DW-1:0] wf_a;
    logic          wf_av;
    logic [DW-1:0] nc_a;
    logic          nc_av;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
  endtask

  task automatic apply(input vec_t v);
    a_en = v.a_en; a_we = v.a_we; a_addr = v.a_addr; a_din = v.a_din;
    b_en = v.b_en; b_we = v.b_we; b_addr = v.b_addr; b_din = v.b_din;
  endtask

  // Called at the negedge where rst was just released; returns at the first
  // negedge with init_busy low, ready to drive the first access.
  task automatic wait_clear(output int n);
    n = 0;
    while (rf_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // One single-cycle port A access, results sampled after the accepting edge.
  task automatic acc_a(input logic [NB-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    a_en = 1'b1; a_we = we; a_addr = addr; a_din = d;
    @(negedge clk);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int n;
    logic [AW-1:0] bb_addr [3];
    logic [DW-1:0] bb_exp  [3];

    //          a_en  a_we   addr   a_din  b_en  b_we   addr   b_din   rf_a  av  rf_b  bv  wf_a  av  nc_a  av
    tbl[0]  = '{1'b1, 8'hFF, 7'd3,  D1,    1'b1, 8'h00, 7'd3,  '0,     '0,   1,  '0,   1,  D1,   1,  '0,   0};
    tbl[1]  = '{1'b1, 8'h0F, 7'd3,  D2,    1'b0, 8'h00, 7'd0,  '0,     D1,   1,  '0,   0,  M3,   1,  '0,   0};
    tbl[2]  = '{1'b1, 8'h00, 7'd3,  '0,    1'b1, 8'h00, 7'd3,  '0,     M3,   1,  M3,   1,  M3,   1,  M3,   1};
    tbl[3]  = '{1'b1, 8'hFF, 7'd7,  64'h1, 1'b0, 8'h00, 7'd0,  '0,     '0,   1,  M3,   0,  64'h1,1,  M3,   0};
    tbl[4]  = '{1'b1, 8'hFF, 7'd7,  64'h2, 1'b0, 8'h00, 7'd0,  '0,     64'h1,1,  M3,   0,  64'h2,1,  M3,   0};
    tbl[5]  = '{1'b1, 8'hFF, 7'd9,  A8,    1'b1, 8'hFF, 7'd9,  B8,     '0,   1,  '0,   1,  A8,   1,  M3,   0};
    tbl[6]  = '{1'b1, 8'h00, 7'd9,  '0,    1'b1, 8'h00, 7'd9,  '0,     A8,   1,  A8,   1,  A8,   1,  A8,   1};
    tbl[7]  = '{1'b1, 8'h0F, 7'd9,  O1,    1'b1, 8'h3C, 7'd9,  T2,     A8,   1,  A8,   1,  W9,   1,  A8,   0};
    tbl[8]  = '{1'b0, 8'h00, 7'd0,  '0,    1'b1, 8'h00, 7'd9,  '0,     A8,   0,  C9,   1,  W9,   0,  A8,   0};
    tbl[9]  = '{1'b1, 8'hFF, 7'd9,  F5,    1'b1, 8'h00, 7'd9,  '0,     C9,   1,  C9,   1,  F5,   1,  A8,   0};
    tbl[10] = '{1'b1, 8'h00, 7'd70, '0,    1'b1, 8'h00, 7'd9,  '0,     '0,   1,  F5,   1,  '0,   1,  '0,   1};
    tbl[11] = '{1'b1, 8'hFF, 7'd70, FF,    1'b1, 8'h00, 7'd3,  '0,     '0,   1,  M3,   1,  '0,   1,  '0,   0};
    tbl[12] = '{1'b1, 8'h00, 7'd6,  '0,    1'b1, 8'h00, 7'd7,  '0,     '0,   1,  64'h2,1,  '0,   1,  '0,   1};

    // Reset state.
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rf a_dout", rf_a_dout, '0);
    chk("reset rf a_vld",  rf_a_vld,  '0);
    chk("reset rf b_dout", rf_b_dout, '0);
    chk("reset rf b_vld",  rf_b_vld,  '0);
    chk("reset wf a_dout", wf_a_dout, '0);
    chk("reset wf a_vld",  wf_a_vld,  '0);
    chk("reset wf b_dout", wf_b_dout, '0);
    chk("reset wf b_vld",  wf_b_vld,  '0);
    chk("reset nc b_dout", nc_b_dout, '0);
    chk("reset nc b_vld",  nc_b_vld,  '0);
    chk("busy during rst rf", rf_busy, 1'b1);
    chk("busy during rst wf", wf_busy, 1'b1);
    chk("busy during rst nc", nc_busy, 1'b1);
    rst = 1'b0;
    wait_clear(n);
    chk("initial clear cycles", n, 64);

    // Clear after reset: preload word 5, pulse rst for one cycle.
    acc_a(8'hFF, 7'd5, 64'hDEAD);
    acc_a(8'h00, 7'd5, '0);
    chk("preload word5 readback", rf_a_dout, 64'hDEAD);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear(n);
    chk("clear cycles after 1-cycle rst", n, 64);
    acc_a(8'hFF, 7'd4, 64'h77);
    acc_a(8'h00, 7'd4, '0);
    chk("word4 readback", rf_a_dout, 64'h77);
    acc_a(8'h00, 7'd5, '0);
    chk("word5 cleared", rf_a_dout, '0);
    chk("word5 read vld", rf_a_vld, 1'b1);

    // Reset mid-clear at counter 30.
    a_en = 1'b1; a_we = 8'hFF; a_addr = 7'd9;  a_din = 64'h1234;
    b_en = 1'b1; b_we = 8'hFF; b_addr = 7'd63; b_din = 64'hABCD;
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("busy at counter 30", rf_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear(n);
    chk("clear cycles after mid-clear rst", n, 64);
    acc_a(8'hFF, 7'd4, 64'h77);
    acc_a(8'h00, 7'd4, '0);
    chk("word4 readback 2", rf_a_dout, 64'h77);
    a_en = 1'b1; a_addr = 7'd9; b_en = 1'b1; b_addr = 7'd63;
    @(negedge clk);
    idle();
    chk("word9 cleared", rf_a_dout, '0);
    chk("word63 cleared", rf_b_dout, '0);
    chk("word63 read vld", rf_b_vld, 1'b1);
    @(negedge clk);

    // Table-driven vectors.
    for (int k = 0; k < NV; k++) begin
      apply(tbl[k]);
      @(negedge clk);
      idle();
      chk($sformatf("v%0d rf a_dout", k), rf_a_dout, tbl[k].rf_a);
      chk($sformatf("v%0d rf a_vld", k),  rf_a_vld,  tbl[k].rf_av);
      chk($sformatf("v%0d rf b_dout", k), rf_b_dout, tbl[k].rf_b);
      chk($sformatf("v%0d rf b_vld", k),  rf_b_vld,  tbl[k].rf_bv);
      chk($sformatf("v%0d nc a_dout", k), nc_a_dout, tbl[k].nc_a);
      chk($sformatf("v%0d nc a_vld", k),  nc_a_vld,  tbl[k].nc_av);
      @(negedge clk);
      chk($sformatf("v%0d wf a_dout", k), wf_a_dout, tbl[k].wf_a);
      chk($sformatf("v%0d wf a_vld", k),  wf_a_vld,  tbl[k].wf_av);
      chk($sformatf("v%0d rf a_vld pulse", k), rf_a_vld, 1'b0);
    end

    // Back-to-back reads: continuous vld, one-cycle lag on the registered DUT.
    bb_addr[0] = 7'd3; bb_addr[1] = 7'd7;  bb_addr[2] = 7'd9;
    bb_exp[0]  = M3;   bb_exp[1]  = 64'h2; bb_exp[2]  = F5;
    a_en = 1'b1; a_we = '0; a_addr = bb_addr[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) a_addr = bb_addr[k+1];
      else       idle();
      chk($sformatf("b2b%0d rf a_dout", k), rf_a_dout, bb_exp[k]);
      chk($sformatf("b2b%0d rf a_vld", k),  rf_a_vld,  1'b1);
      if (k > 0) begin
        chk($sformatf("b2b%0d wf a_dout", k), wf_a_dout, bb_exp[k-1]);
        chk($sformatf("b2b%0d wf a_vld", k),  wf_a_vld,  1'b1);
      end
    end
    @(negedge clk);
    chk("b2b end rf a_vld", rf_a_vld, 1'b0);
    chk("b2b end wf a_dout", wf_a_dout, bb_exp[2]);
    chk("b2b end wf a_vld", wf_a_vld, 1'b1);

    // Reset with a read in flight in the output pipeline.
    acc_a(8'h00, 7'd7, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("inflight wf a_vld cancelled", wf_a_vld, 1'b0);
    chk("inflight wf a_dout reset", wf_a_dout, '0);
    chk("inflight rf a_vld cancelled", rf_a_vld, 1'b0);
    rst = 1'b0;
    wait_clear(n);
    chk("clear cycles after inflight rst", n, 64);
    acc_a(8'h00, 7'd7, '0);
    chk("word7 cleared", rf_a_dout, '0);
    chk("word7 read vld", rf_a_vld, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fm_bram_dp.md
# fm_bram_dp

True dual-port, byte-writable block RAM for the feature-map buffer path. It is the parametrised successor of the single-port feature-map BRAM. It adds:
- a second independent read/write port;
- per-byte write enables;
- selectable read-during-write mode and an optional output register stage;
- read-valid flags;
- a reset-triggered clear sequencer that zeroes the array before first use.

It sits between the DDR streaming engine (port A) and the compute datapath (port B).

## Interface
- BRAM_ADDR_WIDTH, 6, address width of both ports
- BRAM_DATA_WIDTH, 64, word width; must be a multiple of BYTE_WIDTH
- BRAM_DEPTH, 64, number of words; at most 2^BRAM_ADDR_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NB = BRAM_DATA_WIDTH/BYTE_WIDTH
- READ_MODE, 0, same-port read-during-write behaviour: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- OUT_REG, 0, 1 adds one output pipeline register on both ports
- CLEAR_ON_RESET, 1, 1 zeroes every word after reset

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- init_busy  out  1  high while the clear sequence runs; accesses ignored
- a_en  in  1  port A access enable
- a_we  in  NB  port A byte write enables; all-zero means read
- a_addr  in  BRAM_ADDR_WIDTH  port A word address
- a_din  in  BRAM_DATA_WIDTH  port A write data
- a_dout  out  BRAM_DATA_WIDTH  port A read data
- a_vld  out  1  one-cycle pulse, a_dout updated by an accepted access
- b_en, b_we, b_addr, b_din, b_dout, b_vld: identical to port A, for port B

## Operation
Control FSM states:
- CLEAR: entered from any state whenever rst is sampled high, with clear counter = 0.
  - While rst stays high: no writes are performed.
  - On each cycle with rst low: write 0 to word[counter], then counter+1.
  - After writing word BRAM_DEPTH-1: go to READY.
- CLEAR_ON_RESET=0: rst goes to READY the cycle after rst deasserts. Array contents are retained.
- READY: user accesses accepted; remains until rst.
- init_busy = 1 in CLEAR, 0 in READY.
- Reset mid-clear restarts the counter at 0.

Accepting and writing:
- An access is accepted when en=1 in READY. In CLEAR, en is ignored and vld stays 0.
- Write: for each byte lane i with we[i]=1, word[addr] lane i <= din lane i. Other lanes are unchanged.
- addr >= BRAM_DEPTH: the write is dropped, the read returns 0, and vld still pulses.

Read data per accepted access (same port):
- read: dout = stored word;
- write, READ_FIRST: dout = word before the write;
- write, WRITE_FIRST: dout = merged new word, including unwritten lanes;
- write, NO_CHANGE: dout holds and no vld pulse.

Collisions and hold:
- Cross-port read of an address being written by the other port in the same cycle returns the old word, whatever READ_MODE is.
- Both ports write the same address: port A wins on lanes both enable. Lanes enabled by only one port take that port's data.
- dout holds its last value when there is no access.

## Timing
- Reset values: a_dout = b_dout = 0, a_vld = b_vld = 0.
- init_busy = CLEAR_ON_RESET from the cycle after rst is sampled high.
- Clear duration: init_busy stays high for exactly BRAM_DEPTH cycles after rst deasserts. The first access is accepted on the following cycle.
- Read latency, OUT_REG=0: an access accepted at edge N gives dout and vld valid after edge N+1.
- Read latency, OUT_REG=1: valid after edge N+2. The pipeline register is reset to 0 and its vld is cleared by rst.
- Fully pipelined: one accepted access per port per cycle, with no stalls and no backpressure.
- vld is a single-cycle pulse per qualifying access. Back-to-back accesses give a continuous vld.
- rst asserted with accesses in flight: pending vld pulses are cancelled. No partial write occurs after the rst edge.

## Test plan
- Clear after reset: DEPTH=64, CLEAR_ON_RESET=1. Preload word 5 = 0xDEAD, pulse rst 1 cycle → init_busy high 64 cycles; read of word 5 returns 0 with vld.
- Byte write plus WRITE_FIRST: word 3 = 0x1111_2222_3333_4444. Port A writes we=0x0F, din=0xAAAA_BBBB_CCCC_DDDD → a_dout = 0x1111_2222_CCCC_DDDD one cycle later (two with OUT_REG=1).
- Read modes on a write to word 7 (old 0x1, new 0x2): READ_FIRST gives a_dout=0x1 with vld; NO_CHANGE leaves a_dout unchanged and a_vld=0.
- Dual-port collision: both ports write word 9 in the same cycle, A we=0xFF din=0xA..A, B din=0xB..B → word 9 = 0xA..A. Port B reading word 9 while A writes it returns the old value.
- Out-of-range access: read of addr 70 with DEPTH=64 → dout=0, vld=1. Write to addr 70 leaves words 0..63 unchanged.
- Reset mid-clear: rst at clear counter 30 → counter restarts; init_busy stays high for 64 more cycles after rst deasserts; all words are 0.
